// File: rtl/store_buffer_if.sv
// Memory-side request/acknowledge bus between the store buffer and the data memory.
// The store buffer drives it through the master modport; the memory uses the slave modport.
interface store_buffer_if #(
    parameter int DATA_W = 32
);
    logic              MemReq;
    logic [DATA_W-1:0] MemAdr;
    logic [DATA_W-1:0] MemWData;
    logic              MemAck;

    modport master (output MemReq, output MemAdr, output MemWData, input MemAck);
    modport slave  (input MemReq, input MemAdr, input MemWData, output MemAck);
endinterface

// File: rtl/store_buffer.sv
// In-order FIFO write buffer between the core's data port and slow data memory, with load forwarding.
// Optional store coalescing into the youngest entry: define STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic              FwdHit,
    output logic [DATA_W-1:0] FwdData,
    output logic              Empty,
    output logic              Full,
    store_buffer_if.master    mem
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state;
    logic [DATA_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  last_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;
    logic              coalesce;

    assign Full     = (count == CNT_W'(DEPTH));
    assign Empty    = (count == '0);
    assign last_ptr = wr_ptr - PTR_W'(1);
    assign pop      = (state == REQ) && mem.MemAck;

`ifdef STORE_BUFFER_COALESCE_EN
    // The head entry is frozen while it is being offered to memory.
    assign coalesce = MemWrite && !Empty
                      && (addr_q[last_ptr][DATA_W-1:2] == DataAdr[DATA_W-1:2])
                      && !(mem.MemReq && (last_ptr == rd_ptr));
`else
    assign coalesce = 1'b0;
`endif

    assign Stall = MemWrite & Full & ~coalesce;
    assign push  = MemWrite & ~Full & ~coalesce;

    assign mem.MemReq   = (state == REQ);
    assign mem.MemAdr   = addr_q[rd_ptr];
    assign mem.MemWData = data_q[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (!push && pop)
            count_nxt = count - CNT_W'(1);
    end

    // Drain FSM looks at the post-update count so a fresh entry is requested the very next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            case (state)
                IDLE: if (count_nxt != '0) state <= REQ;
                REQ:  if (pop && (count_nxt == '0)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= DataAdr;
            data_q[wr_ptr] <= WriteData;
        end else if (coalesce) begin
            data_q[last_ptr] <= WriteData;
        end
    end

    // Scan oldest to youngest so the last valid match left standing is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        FwdHit  = 1'b0;
        FwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[idx][DATA_W-1:2] == DataAdr[DATA_W-1:2])) begin
                FwdHit  = 1'b1;
                FwdData = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, DATA_W=32).
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Stall;
    logic        FwdHit;
    logic [31:0] FwdData;
    logic        Empty;
    logic        Full;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t log_q[$];

    store_buffer_if #(.DATA_W(32)) mem_if ();

    store_buffer #(.DEPTH(4), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .FwdHit    (FwdHit),
        .FwdData   (FwdData),
        .Empty     (Empty),
        .Full      (Full),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_if.MemReq && mem_if.MemAck)
            log_q.push_back('{mem_if.MemAdr, mem_if.MemWData});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input int idx, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
        if (idx < log_q.size()) e = log_q[idx];
        chk($sformatf("log%0d_adr", idx), e.a, a);
        chk($sformatf("log%0d_data", idx), e.d, d);
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; mem_if.MemAck = 1'b0;
        #12;
        chk("rst_memreq", 32'(mem_if.MemReq), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_fwdhit", 32'(FwdHit), 32'd0);
        chk("rst_fwddata", FwdData, 32'd0);
        reset = 1'b0;
        step();

        // single store, then reset while it is being requested
        MemWrite = 1'b1; DataAdr = 32'h60; WriteData = 32'd3;
        chk("t1_stall", 32'(Stall), 32'd0);
        chk("t1_fwd_empty", 32'(FwdHit), 32'd0);
        step();
        MemWrite = 1'b0;
        chk("t1_memreq", 32'(mem_if.MemReq), 32'd1);
        chk("t1_memadr", mem_if.MemAdr, 32'h60);
        chk("t1_memwdata", mem_if.MemWData, 32'd3);
        chk("t1_empty", 32'(Empty), 32'd0);
        chk("t1_fwdhit", 32'(FwdHit), 32'd1);
        chk("t1_fwddata", FwdData, 32'd3);
        step();
        chk("t1_memreq_hold", 32'(mem_if.MemReq), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_memreq", 32'(mem_if.MemReq), 32'd0);
        chk("t1_async_empty", 32'(Empty), 32'd1);
        #2 reset = 1'b0;
        mem_if.MemAck = 1'b1;
        step();
        chk("t1_idle_ack_memreq", 32'(mem_if.MemReq), 32'd0);
        chk("t1_idle_ack_empty", 32'(Empty), 32'd1);
        mem_if.MemAck = 1'b0;

        // fill to full, stall a fifth store, release with a single ack
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'h60 + 32'(4 * i); WriteData = 32'(i + 1);
            step();
        end
        chk("t2_full", 32'(Full), 32'd1);
        chk("t2_memadr_head", mem_if.MemAdr, 32'h60);
        DataAdr = 32'h70; WriteData = 32'd5;
        chk("t2_stall", 32'(Stall), 32'd1);
        step();
        chk("t2_still_full", 32'(Full), 32'd1);
        chk("t2_still_stall", 32'(Stall), 32'd1);
        mem_if.MemAck = 1'b1;
        step();
        mem_if.MemAck = 1'b0;
        chk("t2_pop_full", 32'(Full), 32'd0);
        chk("t2_pop_stall", 32'(Stall), 32'd0);
        chk("t2_memadr_next", mem_if.MemAdr, 32'h64);
        step();
        MemWrite = 1'b0;
        chk("t2_refull", 32'(Full), 32'd1);
        DataAdr = 32'h70;
        #1 chk("t2_fwd70_hit", 32'(FwdHit), 32'd1);
        chk("t2_fwd70_data", FwdData, 32'd5);
        DataAdr = 32'h62;
        #1 chk("t2_fwd60_gone", 32'(FwdHit), 32'd0);
        chk("t2_fwd60_data", FwdData, 32'd0);
        DataAdr = 32'h6B;
        #1 chk("t2_fwd68_data", FwdData, 32'd3);
        mem_if.MemAck = 1'b1;
        repeat (4) step();
        mem_if.MemAck = 1'b0;
        chk("t2_drained_memreq", 32'(mem_if.MemReq), 32'd0);
        chk("t2_drained_empty", 32'(Empty), 32'd1);
        chk("t2_log_size", 32'(log_q.size()), 32'd5);
        chk_log(0, 32'h60, 32'd1);
        chk_log(1, 32'h64, 32'd2);
        chk_log(4, 32'h70, 32'd5);

        // same word stored twice: youngest forwards, both drain in order
        log_q.delete();
        MemWrite = 1'b1; DataAdr = 32'h64; WriteData = 32'd7;
        step();
        WriteData = 32'd9;
        step();
        MemWrite = 1'b0; DataAdr = 32'h66;
        #1 chk("t3_fwdhit", 32'(FwdHit), 32'd1);
        chk("t3_fwddata", FwdData, 32'd9);
        mem_if.MemAck = 1'b1;
        repeat (2) step();
        mem_if.MemAck = 1'b0;
        chk("t3_log_size", 32'(log_q.size()), 32'd2);
        chk_log(0, 32'h64, 32'd7);
        chk_log(1, 32'h64, 32'd9);
        chk("t3_empty", 32'(Empty), 32'd1);

        // streaming: one store per cycle with ack held high
        log_q.delete();
        mem_if.MemAck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            MemWrite = 1'b1; DataAdr = 32'h60 + 32'(4 * i); WriteData = 32'h100 + 32'(i);
            #1 chk($sformatf("t4_stall%0d", i), 32'(Stall), 32'd0);
            if (i > 0) chk($sformatf("t4_memreq%0d", i), 32'(mem_if.MemReq), 32'd1);
            step();
        end
        MemWrite = 1'b0;
        step();
        mem_if.MemAck = 1'b0;
        chk("t4_log_size", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk_log(i, 32'h60 + 32'(4 * i), 32'h100 + 32'(i));
        chk("t4_empty", 32'(Empty), 32'd1);

`ifdef STORE_BUFFER_COALESCE_EN
        // full buffer, store to the youngest word merges in place
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'h60 + 32'(4 * i); WriteData = 32'(i + 1);
            step();
        end
        DataAdr = 32'h6C; WriteData = 32'hAA;
        #1 chk("t5_stall", 32'(Stall), 32'd0);
        step();
        MemWrite = 1'b0;
        chk("t5_full", 32'(Full), 32'd1);
        chk("t5_memadr", mem_if.MemAdr, 32'h60);
        mem_if.MemAck = 1'b1;
        repeat (4) step();
        mem_if.MemAck = 1'b0;
        chk("t5_log_size", 32'(log_q.size()), 32'd4);
        chk_log(3, 32'h6C, 32'hAA);
        chk("t5_empty", 32'(Empty), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer downstream of the single-cycle ARM core's data-memory port.
- Accepts stores (MemWrite, DataAdr, WriteData) in one cycle and drains them in order to a slower data memory over a req/ack handshake.
- Forwards buffered data to core loads so read-after-write stays correct.
- Stalls the core only when the buffer is full.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- DATA_W, 32, width of data and address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  core store strobe; a store is accepted at the posedge when Stall is 0.
- DataAdr  in  DATA_W  core store address; also the load address used for forwarding.
- WriteData  in  DATA_W  core store data.
- Stall  out  1  combinational; equals MemWrite & Full.
- FwdHit  out  1  combinational; a valid entry has word address DataAdr[31:2].
- FwdData  out  DATA_W  data of the youngest matching entry; 0 when FwdHit is 0.
- MemReq  out  1  request to data memory.
- MemAdr  out  DATA_W  head entry address.
- MemWData  out  DATA_W  head entry data.
- MemAck  in  1  memory completes the head store at this posedge.
- Empty  out  1  no valid entries.
- Full  out  1  count equals DEPTH.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {addr, data}.
  - Pointers wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- Reset (async):
  - wr_ptr = rd_ptr = count = 0.
  - FSM goes to IDLE.
  - MemReq = 0, Empty = 1, Full = 0, FwdHit = 0, FwdData = 0.
  - Entry contents are don't-care.
  - Reset asserted mid-handshake discards all entries. MemReq drops asynchronously. Any later MemAck is ignored until the FSM is in REQ again.
- Enqueue:
  - At a posedge with MemWrite = 1 and Full = 0, write {DataAdr, WriteData} at wr_ptr, then increment wr_ptr.
  - Enqueue latency is zero cycles. The entry is visible to forwarding and, if the buffer was empty, to MemReq in the next cycle.
- Drain FSM:
  - IDLE: MemReq = 0. Go to REQ when count != 0.
  - REQ: MemReq = 1. MemAdr/MemWData show the head entry and stay stable until MemAck.
  - On MemAck in REQ: pop the head (rd_ptr+1). Stay in REQ if count after the update is nonzero, else go to IDLE.
  - Back-to-back drains are permitted: one store per cycle when MemAck is held high.
  - MemAck in IDLE is ignored.
- Simultaneous events:
  - Enqueue and pop in the same cycle: count is unchanged and both pointers advance.
  - Full with MemWrite and MemAck in the same cycle: Stall = 1 and no enqueue that cycle. The pop still happens, and the store is accepted the following cycle.
  - Empty with MemWrite: the entry is enqueued. MemReq rises the next cycle; there is no bypass to memory.
- Forwarding:
  - Compare DataAdr[31:2] against the addr[31:2] of every valid entry.
  - The youngest match wins, by age order from rd_ptr.
  - Forwarding is purely combinational and independent of MemWrite.
- Byte offsets: DataAdr[1:0] are ignored everywhere (word-only stores).
- Full/Empty are registered from count: Full = (count == DEPTH), Empty = (count == 0).

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- When defined:
  - A store whose word address matches the youngest valid entry overwrites that entry's data in place. count and wr_ptr are unchanged.
  - Coalescing applies only if that entry is not the head while MemReq = 1.
  - A coalescing store is accepted even when Full, so Stall = MemWrite & Full & ~coalesce.
- When undefined: every store allocates a new entry, exactly as above.

Test Plan:
- Reset, then a store to 0x60 with data 3, with MemAck tied 0 → next cycle MemReq=1, MemAdr=0x60, MemWData=3, Empty=0. Assert reset mid-request → MemReq=0 and Empty=1 immediately.
- DEPTH=4, stores to 0x60,0x64,0x68,0x6C with data 1..4, then a fifth store (0x70, data 5) while MemAck=0 → Full=1, Stall=1. Pulse MemAck one cycle → the fifth store is accepted the cycle after, and MemAdr=0x64.
- Stores 0x64←7 then 0x64←9 without draining; DataAdr=0x66 → FwdHit=1, FwdData=9 (youngest wins). Without the macro, drain order at memory is 7 then 9.
- MemAck held 1 while storing every cycle to 0x60+4i for i=0..7 → MemReq high continuously. The memory sees all 8 stores in order and Stall stays 0.
- Full buffer, MemWrite=1 and MemAck=1 in the same cycle → no enqueue that cycle, count goes 4→3, then back to 4 the next cycle.
- With STORE_BUFFER_COALESCE_EN: Full with youngest entry 0x6C, store 0x6C←0xAA → Stall=0 and count stays 4. The memory receives 0xAA at 0x6C.
